// File: rtl/cc_arb_pkg.sv
// cc_arb_pkg: shared types and constants for the memory read-channel arbiter
// Contents: ATTR_W (AR attribute width), ar_attr_t (packed arlen/arsize/arburst), arb_state_t (IDLE/ADDR/DATA)
package cc_arb_pkg;
  localparam int ATTR_W = 9;
  typedef struct packed {
    logic [3:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst;
  } ar_attr_t;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t;
endpackage

// File: rtl/cc_arb_picker.sv
// cc_arb_picker: combinational winner select over a request vector
// Ports: i_req request vector, i_last previous winner (CC_ARB_RR_EN only), o_gnt_oh one-hot grant, o_gnt_idx grant index
// Macro CC_ARB_RR_EN: defined = round-robin starting after i_last, undefined = fixed priority (lowest index wins)
module cc_arb_picker #(
  parameter int NUM_REQ = 2,
  localparam int LW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
`ifdef CC_ARB_RR_EN
  input  logic [LW-1:0]      i_last,
`endif
  output logic [NUM_REQ-1:0] o_gnt_oh,
  output logic [LW-1:0]      o_gnt_idx
);
`ifdef CC_ARB_RR_EN
  logic          w_hit;
  logic [LW-1:0] w_cand;
  always_comb begin
    o_gnt_idx = '0;
    w_hit = 1'b0;
    w_cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = LW'((int'(i_last) + k) % NUM_REQ);
      if (!w_hit && i_req[w_cand]) begin
        o_gnt_idx = w_cand;
        w_hit = 1'b1;
      end
    end
  end
`else
  always_comb begin
    o_gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (i_req[k]) o_gnt_idx = LW'(k);
  end
`endif
  assign o_gnt_oh = (|i_req) ? (NUM_REQ'(1) << o_gnt_idx) : '0;
endmodule

// File: rtl/cc_mem_rd_arbiter.sv
// cc_mem_rd_arbiter: shares one memory-side AXI read port (AR+R) among NUM_REQ requesters, one burst outstanding
// Ports: clk/rst_n (sync active-low); s_ar* per-requester AR in, s_arready_o one-hot; s_r* R out routed to the grant;
//        m_ar* registered AR to memory; m_r* R from memory, m_rready_o follows the granted requester
// Macro CC_ARB_RR_EN: defined = round-robin arbitration with a last-grant register, undefined = fixed priority
module cc_mem_rd_arbiter
  import cc_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    s_arvalid_i,
  output logic [NUM_REQ-1:0]                    s_arready_o,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    s_araddr_i,
  input  logic [NUM_REQ-1:0][ID_WIDTH-1:0]      s_arid_i,
  input  logic [NUM_REQ-1:0][ATTR_W-1:0]        s_arattr_i,
  output logic [NUM_REQ-1:0]                    s_rvalid_o,
  input  logic [NUM_REQ-1:0]                    s_rready_i,
  output logic [63:0]                           s_rdata_o,
  output logic [ID_WIDTH-1:0]                   s_rid_o,
  output logic [1:0]                            s_rresp_o,
  output logic                                  s_rlast_o,
  output logic                                  m_arvalid_o,
  input  logic                                  m_arready_i,
  output logic [ADDR_WIDTH-1:0]                 m_araddr_o,
  output logic [ID_WIDTH-1:0]                   m_arid_o,
  output logic [ATTR_W-1:0]                     m_arattr_o,
  input  logic                                  m_rvalid_i,
  output logic                                  m_rready_o,
  input  logic [63:0]                           m_rdata_i,
  input  logic [1:0]                            m_rresp_i,
  input  logic                                  m_rlast_i
);
  localparam int LW = $clog2(NUM_REQ);
  arb_state_t            r_state, w_next;
  logic [LW-1:0]         r_gnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ID_WIDTH-1:0]   r_id;
  ar_attr_t              r_attr;
  logic [NUM_REQ-1:0]    w_gnt_oh;
  logic [LW-1:0]         w_gnt_idx;
  logic                  w_accept;
`ifdef CC_ARB_RR_EN
  logic [LW-1:0]         r_last;
  cc_arb_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_req    (s_arvalid_i),
    .i_last   (r_last),
    .o_gnt_oh (w_gnt_oh),
    .o_gnt_idx(w_gnt_idx)
  );
  always_ff @(posedge clk)
    if (!rst_n) r_last <= LW'(NUM_REQ - 1);
    else if (w_accept) r_last <= w_gnt_idx;
`else
  cc_arb_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_req    (s_arvalid_i),
    .o_gnt_oh (w_gnt_oh),
    .o_gnt_idx(w_gnt_idx)
  );
`endif
  assign w_accept    = rst_n && r_state == IDLE && |s_arvalid_i;
  assign m_araddr_o  = r_addr;
  assign m_arid_o    = r_id;
  assign m_arattr_o  = r_attr;
  assign s_rid_o     = r_id;
  assign s_rdata_o   = m_rdata_i;
  assign s_rresp_o   = m_rresp_i;
  assign s_rlast_o   = m_rlast_i;
  // Handshake outputs are forced low while rst_n is asserted so the first reset cycle is already quiet.
  always_comb begin
    w_next = r_state;
    s_arready_o = '0;
    s_rvalid_o = '0;
    m_arvalid_o = 1'b0;
    m_rready_o = 1'b0;
    if (rst_n)
      case (r_state)
        IDLE: begin
          s_arready_o = w_gnt_oh;
          if (|s_arvalid_i) w_next = ADDR;
        end
        ADDR: begin
          m_arvalid_o = 1'b1;
          if (m_arready_i) w_next = DATA;
        end
        DATA: begin
          s_rvalid_o[r_gnt] = m_rvalid_i;
          m_rready_o = s_rready_i[r_gnt];
          if (m_rvalid_i && s_rready_i[r_gnt] && m_rlast_i) w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt <= '0;
      r_addr <= '0;
      r_id <= '0;
      r_attr <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_gnt <= w_gnt_idx;
        r_addr <= s_araddr_i[w_gnt_idx];
        r_id <= s_arid_i[w_gnt_idx];
        r_attr <= ar_attr_t'(s_arattr_i[w_gnt_idx]);
      end
    end
endmodule

// File: tb/tb_cc_mem_rd_arbiter.sv
// tb_cc_mem_rd_arbiter: directed plus randomized checks of cc_mem_rd_arbiter against a request-level reference model
module tb_cc_mem_rd_arbiter;
  localparam int N = 2, IW = 4, AW = 32, AT = 9;
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] s_arvalid_i, s_arready_o, s_rvalid_o, s_rready_i;
  logic [N-1:0][AW-1:0] s_araddr_i;
  logic [N-1:0][IW-1:0] s_arid_i;
  logic [N-1:0][AT-1:0] s_arattr_i;
  logic [63:0] s_rdata_o, m_rdata_i;
  logic [IW-1:0] s_rid_o, m_arid_o;
  logic [1:0] s_rresp_o, m_rresp_i;
  logic s_rlast_o, m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o, m_rlast_i;
  logic [AW-1:0] m_araddr_o;
  logic [AT-1:0] m_arattr_o;
  int n_assert = 0, n_fail = 0;
  int m_last;
  logic [IW-1:0] exp_rid;
  always #5 clk = ~clk;
  cc_mem_rd_arbiter #(.NUM_REQ(N), .ID_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o), .s_araddr_i(s_araddr_i),
    .s_arid_i(s_arid_i), .s_arattr_i(s_arattr_i),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i), .s_rdata_o(s_rdata_o),
    .s_rid_o(s_rid_o), .s_rresp_o(s_rresp_o), .s_rlast_o(s_rlast_o),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_araddr_o(m_araddr_o),
    .m_arid_o(m_arid_o), .m_arattr_o(m_arattr_o),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .m_rdata_i(m_rdata_i),
    .m_rresp_i(m_rresp_i), .m_rlast_i(m_rlast_i)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] req);
`ifdef CC_ARB_RR_EN
    for (int k = 1; k <= N; k++) if (req[(m_last + k) % N]) return (m_last + k) % N;
`else
    for (int k = 0; k < N; k++) if (req[k]) return k;
`endif
    return -1;
  endfunction
  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [AT-1:0] at);
    s_araddr_i[i] = a;
    s_arid_i[i] = id;
    s_arattr_i[i] = at;
  endtask
  // Called at a negedge: presents req, checks the grant, then walks the ADDR phase with ar_stall refused cycles.
  task automatic do_ar(input logic [N-1:0] req, input bit hold, input int ar_stall, output int g);
    int w;
    logic [N-1:0] oh;
    logic [AW-1:0] e_addr;
    logic [AT-1:0] e_attr;
    s_arvalid_i = req;
    #1;
    w = pick(req);
    oh = '0;
    oh[w] = 1'b1;
    chk("ar_accept", 64'(s_arready_o), 64'(oh));
    g = 0;
    for (int k = 0; k < N; k++) if (s_arready_o[k]) g = k;
    e_addr = s_araddr_i[w];
    exp_rid = s_arid_i[w];
    e_attr = s_arattr_i[w];
    m_last = w;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      s_arvalid_i = req & ~oh;
      set_req(w, AW'($urandom), IW'($urandom), AT'($urandom));
    end
    for (int c = 0; c <= ar_stall; c++) begin
      if (c > 0) @(negedge clk);
      m_arready_i = (c == ar_stall);
      m_rvalid_i = 1'b1;
      #1;
      chk("m_arvalid", 64'(m_arvalid_o), 64'(1));
      chk("m_araddr", 64'(m_araddr_o), 64'(e_addr));
      chk("m_arid", 64'(m_arid_o), 64'(exp_rid));
      chk("m_arattr", 64'(m_arattr_o), 64'(e_attr));
      chk("no_2nd_arready", 64'(s_arready_o), 64'(0));
      chk("addr_r_held", 64'({m_rready_o, s_rvalid_o}), 64'(0));
      @(posedge clk);
    end
    @(negedge clk);
    m_arready_i = 1'b0;
    m_rvalid_i = 1'b0;
  endtask
  // Called at a negedge in DATA; runs beats, optionally stalling the requester before beat stall_at; ends at a negedge.
  task automatic do_r(input int w, input int beats, input int stall_at, input int stall_len, input bit abort);
    int seen = 0;
    logic [63:0] d;
    logic [1:0] rs;
    logic lst;
    logic [N-1:0] oh;
    oh = '0;
    oh[w] = 1'b1;
    for (int i = 0; i < beats; i++) begin
      d = {$urandom, $urandom};
      rs = 2'($urandom);
      lst = !abort && i == beats - 1;
      if (i > 0) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        s_rready_i = '1;
        m_rvalid_i = 1'b0;
        #1;
        chk("gap_svalid", 64'(s_rvalid_o), 64'(0));
        chk("gap_mrready", 64'(m_rready_o), 64'(1));
        @(posedge clk);
        @(negedge clk);
      end
      m_rvalid_i = 1'b1;
      m_rdata_i = d;
      m_rresp_i = rs;
      m_rlast_i = lst;
      if (i == stall_at)
        for (int c = 0; c < stall_len; c++) begin
          s_rready_i = ~oh;
          #1;
          chk("stall_mrready", 64'(m_rready_o), 64'(0));
          chk("stall_svalid", 64'(s_rvalid_o), 64'(oh));
          @(posedge clk);
          @(negedge clk);
        end
      s_rready_i = '1;
      #1;
      chk("beat_svalid", 64'(s_rvalid_o), 64'(oh));
      chk("beat_mrready", 64'(m_rready_o), 64'(1));
      chk("beat_data", s_rdata_o, d);
      chk("beat_resp", 64'(s_rresp_o), 64'(rs));
      chk("beat_last", 64'(s_rlast_o), 64'(lst));
      chk("beat_rid", 64'(s_rid_o), 64'(exp_rid));
      if (s_rvalid_o[w] && s_rready_i[w] && m_rready_o) seen++;
      @(posedge clk);
    end
    @(negedge clk);
    m_rvalid_i = 1'b0;
    m_rlast_i = 1'b0;
    chk("beat_count", 64'(seen), 64'(beats));
  endtask
  initial begin
    int g;
    int fair_exp[4];
    logic [N-1:0] req;
`ifdef CC_ARB_RR_EN
    fair_exp = '{0, 1, 0, 1};
`else
    fair_exp = '{0, 0, 0, 0};
`endif
    rst_n = 1'b0;
    s_arvalid_i = '0;
    s_rready_i = '1;
    m_arready_i = 1'b0;
    m_rvalid_i = 1'b0;
    m_rlast_i = 1'b0;
    m_rdata_i = '0;
    m_rresp_i = '0;
    for (int i = 0; i < N; i++) set_req(i, '0, '0, '0);
    m_last = N - 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid_ready", 64'({s_arready_o, s_rvalid_o, m_arvalid_o, m_rready_o}), 64'(0));
    chk("rst_m_ar", 64'({m_araddr_o, m_arid_o, m_arattr_o}), 64'(0));
    chk("rst_rid", 64'(s_rid_o), 64'(0));
    rst_n = 1'b1;
    set_req(0, 32'h0000_1240, 4'd3, {4'd7, 3'd3, 2'd1});
    do_ar(2'b01, 1'b0, 0, g);
    chk("single_gnt", 64'(g), 64'(0));
    do_r(g, 8, 99, 0, 1'b0);
    m_rvalid_i = 1'b1;
    #1;
    chk("stray_mrready", 64'(m_rready_o), 64'(0));
    chk("stray_svalid", 64'(s_rvalid_o), 64'(0));
    @(negedge clk);
    m_rvalid_i = 1'b0;
    set_req(1, AW'($urandom), IW'($urandom), AT'($urandom));
    do_ar(2'b10, 1'b0, 6, g);
    do_r(g, 4, 99, 0, 1'b0);
    set_req(1, AW'($urandom), IW'($urandom), AT'($urandom));
    do_ar(2'b10, 1'b0, 0, g);
    do_r(g, 8, 3, 5, 1'b0);
    for (int i = 0; i < N; i++) set_req(i, AW'($urandom), IW'($urandom), AT'($urandom));
    for (int k = 0; k < 4; k++) begin
      do_ar(2'b11, 1'b1, 0, g);
      chk("fair_order", 64'(g), 64'(fair_exp[k]));
      do_r(g, $urandom_range(1, 8), 99, 0, 1'b0);
    end
    s_arvalid_i = '0;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < N; i++)
        if (!s_arvalid_i[i]) set_req(i, AW'($urandom), IW'($urandom), AT'($urandom));
      req = s_arvalid_i | N'($urandom_range(0, 3));
      if (req == '0) req = N'(1);
      do_ar(req, 1'b0, $urandom_range(0, 3), g);
      do_r(g, $urandom_range(1, 8), $urandom_range(0, 7), $urandom_range(0, 3), 1'b0);
    end
    s_arvalid_i = '0;
    do_ar(2'b10, 1'b0, 0, g);
    do_r(g, 3, 99, 0, 1'b1);
    rst_n = 1'b0;
    s_arvalid_i = '1;
    m_rvalid_i = 1'b1;
    s_rready_i = '1;
    #1;
    chk("midrst_valid_ready", 64'({s_arready_o, s_rvalid_o, m_arvalid_o, m_rready_o}), 64'(0));
    @(negedge clk);
    #1;
    chk("midrst_valid_ready2", 64'({s_arready_o, s_rvalid_o, m_arvalid_o, m_rready_o}), 64'(0));
    chk("midrst_m_ar", 64'({m_araddr_o, m_arid_o, m_arattr_o}), 64'(0));
    chk("midrst_rid", 64'(s_rid_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    m_rvalid_i = 1'b0;
    m_last = N - 1;
    do_ar(2'b11, 1'b0, 0, g);
    chk("post_rst_first", 64'(g), 64'(0));
    do_r(g, 2, 99, 0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
